// File: rtl/nts_memory_pkg.sv
// Shared types and helpers for the 64-bit-word BRAM read and write paths.
package nts_memory_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_ERROR = 3'd7
  } rd_state_t;

  localparam int RD_FIFO_DEPTH = 2;

  // Joins the tail of the previous word with the head of the current one, so the
  // output starts at byte offset lo of the previous word (byte 0 in [63:56]).
  function automatic logic [63:0] merge_lanes(input logic [63:0] prev,
                                              input logic [63:0] data,
                                              input logic [2:0]  lo);
    logic [6:0] sh;
    if (lo == 3'd0) return data;
    sh = {1'b0, lo, 3'b000};
    return (prev << sh) | (data >> (7'd64 - sh));
  endfunction

endpackage

// File: rtl/memory_read_fifo.sv
// Two-entry first-word-fall-through FIFO carrying {last, data} toward the stream output.
module memory_read_fifo
  import nts_memory_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_areset_n,
  input  logic        i_push,
  input  logic [64:0] i_push_data,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [64:0] o_data,
  output logic [1:0]  o_count
);

  logic [64:0] mem_q [RD_FIFO_DEPTH];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic        pop;
  logic        push_ok;

  assign pop     = o_valid && i_ready;
  assign push_ok = i_push && ((count_q != 2'(RD_FIFO_DEPTH)) || pop);

  // NOTE: the two entries are reset so the stream output reads 0 after reset;
  // a deep RAM-backed FIFO would leave its storage unreset.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      for (int i = 0; i < RD_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (push_ok) begin
        mem_q[wr_ptr_q] <= i_push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push_ok) - 2'(pop);
    end
  end

  assign o_valid = (count_q != 2'd0);
  assign o_data  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/memory_burst_reader.sv
// Burst reader: fetches consecutive 64-bit RAM words, realigns to a byte offset, streams them out.
// Optional start-time range check enabled by MEMORY_BURST_READER_BOUNDS_CHECK_EN.
module memory_burst_reader
  import nts_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_areset_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_addr_hi,
  input  logic [2:0]            i_addr_lo,
  input  logic [LEN_WIDTH-1:0]  i_length,
  output logic                  o_busy,
  output logic                  o_error,
  output logic                  o_ram_en,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  input  logic [63:0]           i_ram_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [63:0]           o_data,
  output logic                  o_last
);

  localparam int CW = LEN_WIDTH + 1;

  rd_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            lo_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [CW-1:0]         fetch_q, issued_q, pushed_q;
  logic [CW-1:0]         fetch_cnt;
  logic                  rd_pending_q, first_q;
  logic [63:0]           prev_q;
  logic [1:0]            fifo_count;
  logic [64:0]           fifo_data;
  logic [2:0]            occupancy;
  logic                  pop_now, issue, push, prime, bounds_err, start_go;

  assign fetch_cnt = CW'(i_length) + CW'(i_addr_lo != 3'd0);

`ifdef MEMORY_BURST_READER_BOUNDS_CHECK_EN
  localparam int EW = ADDR_WIDTH + CW + 1;
  logic [EW-1:0] end_addr;
  assign end_addr   = EW'(i_addr_hi) + EW'(fetch_cnt) - EW'(1);
  assign bounds_err = end_addr > EW'((1 << ADDR_WIDTH) - 1);
  assign o_error    = (state_q == ST_ERROR);
`else
  assign bounds_err = 1'b0;
  assign o_error    = 1'b0;
`endif

  // Words committed downstream: queued, about to return, minus the one leaving now.
  assign pop_now   = o_valid && i_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, rd_pending_q} - {2'b00, pop_now};
  assign issue     = (state_q == ST_FETCH) && (occupancy < 3'd2);
  assign prime     = first_q && (lo_q != 3'd0);
  assign push      = rd_pending_q && !prime;
  assign start_go  = (state_q == ST_IDLE) && i_start && (i_length != '0) && !bounds_err;

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_start && i_length != '0) state_d = bounds_err ? ST_ERROR : ST_FETCH;
      ST_FETCH: if (issue && (issued_q + CW'(1) == fetch_q)) state_d = ST_DRAIN;
      ST_DRAIN: if (!rd_pending_q && fifo_count == 2'd0) state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      lo_q         <= '0;
      len_q        <= '0;
      fetch_q      <= '0;
      issued_q     <= '0;
      pushed_q     <= '0;
      rd_pending_q <= 1'b0;
      first_q      <= 1'b0;
      prev_q       <= '0;
    end else begin
      state_q      <= state_d;
      rd_pending_q <= issue;
      if (start_go) begin
        addr_q   <= i_addr_hi;
        lo_q     <= i_addr_lo;
        len_q    <= i_length;
        fetch_q  <= fetch_cnt;
        issued_q <= '0;
        pushed_q <= '0;
        first_q  <= 1'b1;
      end
      if (issue) begin
        addr_q   <= addr_q + 1'b1;
        issued_q <= issued_q + CW'(1);
      end
      if (rd_pending_q) begin
        first_q <= 1'b0;
        prev_q  <= i_ram_data;
      end
      if (push) pushed_q <= pushed_q + CW'(1);
    end
  end

  memory_read_fifo u_fifo (
    .i_clk       (i_clk),
    .i_areset_n  (i_areset_n),
    .i_push      (push),
    .i_push_data ({(pushed_q + CW'(1)) == CW'(len_q), merge_lanes(prev_q, i_ram_data, lo_q)}),
    .i_ready     (i_ready),
    .o_valid     (o_valid),
    .o_data      (fifo_data),
    .o_count     (fifo_count)
  );

  assign o_busy     = (state_q != ST_IDLE);
  assign o_ram_en   = issue;
  assign o_ram_addr = addr_q;
  assign o_data     = fifo_data[63:0];
  assign o_last     = o_valid && fifo_data[64];

endmodule

// File: tb/tb_memory_burst_reader.sv
// Scoreboard bench for memory_burst_reader: byte-ramp RAM model, expected words queued at start.
module tb_memory_burst_reader;

  localparam int AW = 8;
  localparam int LW = 8;

  logic          i_clk = 1'b0;
  logic          i_areset_n = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_addr_hi = '0;
  logic [2:0]    i_addr_lo = '0;
  logic [LW-1:0] i_length = '0;
  logic          i_ready = 1'b1;
  logic [63:0]   i_ram_data;
  logic          o_busy, o_error, o_ram_en, o_valid, o_last;
  logic [AW-1:0] o_ram_addr;
  logic [63:0]   o_data;

  memory_burst_reader #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .i_clk      (i_clk),
    .i_areset_n (i_areset_n),
    .i_start    (i_start),
    .i_addr_hi  (i_addr_hi),
    .i_addr_lo  (i_addr_lo),
    .i_length   (i_length),
    .o_busy     (o_busy),
    .o_error    (o_error),
    .o_ram_en   (o_ram_en),
    .o_ram_addr (o_ram_addr),
    .i_ram_data (i_ram_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_last     (o_last)
  );

  always #5 i_clk = ~i_clk;

  logic [63:0] ram [256];
  logic [63:0] ram_q = '0;
  assign i_ram_data = ram_q;
  always @(posedge i_clk) if (o_ram_en) ram_q <= ram[o_ram_addr];

  int            n_checks = 0;
  int            n_pass = 0;
  logic [64:0]   sb [$];
  logic [AW-1:0] addr_log [$];
  int            ready_mode = 0;
  int            rdy_ph = 0;

  task automatic check(input string tag, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [63:0] exp_word(input int base, input int j);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[63-8*i -: 8] = 8'((base + 8*j + i) & 255);
    return w;
  endfunction

  task automatic push_expected(input logic [AW-1:0] hi, input logic [2:0] lo, input logic [LW-1:0] len);
    int base = int'(hi) * 8 + int'(lo);
    for (int j = 0; j < int'(len); j++)
      sb.push_back({(j == int'(len) - 1), exp_word(base, j)});
  endtask

  task automatic start_burst(input logic [AW-1:0] hi, input logic [2:0] lo, input logic [LW-1:0] len);
    @(negedge i_clk);
    i_addr_hi = hi;
    i_addr_lo = lo;
    i_length  = len;
    i_start   = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((o_busy || sb.size() != 0) && n < 1000) begin
      @(posedge i_clk);
      #1 n++;
    end
    check({tag, "_done"}, 65'(o_busy || sb.size() != 0), 65'h0);
  endtask

  task automatic run_burst(input string tag, input logic [AW-1:0] hi, input logic [2:0] lo,
                           input logic [LW-1:0] len, input int exp_lat);
    int lat = 1;
    push_expected(hi, lo, len);
    addr_log.delete();
    start_burst(hi, lo, len);
    while (!o_valid && lat < 50) begin
      @(posedge i_clk);
      #1 lat++;
    end
    check({tag, "_latency"}, 65'(lat), 65'(exp_lat));
    wait_done(tag);
  endtask

  // Ready driver: 0 = held high, 1 = pattern 1,0,0,1, 2 = held low.
  initial forever begin
    @(posedge i_clk);
    #1;
    case (ready_mode)
      1: begin
        i_ready = (rdy_ph == 0) || (rdy_ph == 3);
        rdy_ph  = (rdy_ph + 1) % 4;
      end
      2:       i_ready = 1'b0;
      default: i_ready = 1'b1;
    endcase
  end

  // Monitor: pops the scoreboard on each handshake and checks stalled words hold.
  logic        stall_q = 1'b0;
  logic [64:0] stall_data = '0;
  always @(negedge i_clk) begin
    if (!i_areset_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid", 65'(o_valid), 65'h1);
        check("stall_data", {o_last, o_data}, stall_data);
      end
      if (o_ram_en) addr_log.push_back(o_ram_addr);
      if (o_valid && i_ready) begin
        if (sb.size() == 0) check("extra_word", 65'(o_valid), 65'h0);
        else check("word", {o_last, o_data}, sb.pop_front());
      end
      stall_q    = o_valid && !i_ready;
      stall_data = {o_last, o_data};
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int any_busy;
    int err_cnt;
    int n;

    for (int k = 0; k < 256; k++)
      for (int i = 0; i < 8; i++) ram[k][63-8*i -: 8] = 8'((8*k + i) & 255);

    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ctrl", {62'h0, o_busy, o_valid, o_ram_en}, 65'h0);
    check("rst_data", {o_last, o_data}, 65'h0);
    check("rst_error", 65'(o_error), 65'h0);
    @(negedge i_clk) i_areset_n = 1'b1;
    repeat (2) @(posedge i_clk);

    // 1: aligned single word
    run_burst("t1", 8'd2, 3'd0, 8'd1, 3);
    check("t1_busy", 65'(o_busy), 65'h0);

    // 2: offset 3, two words
    run_burst("t2", 8'd2, 3'd3, 8'd2, 4);
    check("t2_naddr", 65'(addr_log.size()), 65'd3);
    if (addr_log.size() == 3)
      for (int i = 0; i < 3; i++) check("t2_addr", 65'(addr_log[i]), 65'(2 + i));

    // 3: offset 7, four words, consumer stalls
    ready_mode = 1;
    run_burst("t3", 8'd0, 3'd7, 8'd4, 4);
    ready_mode = 0;
    @(posedge i_clk);

    // 4a: zero length is a no-op
    addr_log.delete();
    start_burst(8'd4, 3'd0, 8'd0);
    any_busy = int'(o_busy);
    repeat (6) begin
      @(posedge i_clk);
      #1 any_busy |= int'(o_busy);
    end
    check("len0_busy", 65'(any_busy), 65'h0);
    check("len0_ram_en", 65'(addr_log.size()), 65'h0);

    // 4b: start while busy is ignored
    addr_log.delete();
    push_expected(8'd5, 3'd0, 8'd2);
    start_burst(8'd5, 3'd0, 8'd2);
    @(negedge i_clk);
    check("busy_during", 65'(o_busy), 65'h1);
    i_addr_hi = 8'd9;
    i_length  = 8'd3;
    i_start   = 1'b1;
    repeat (2) @(negedge i_clk);
    i_start = 1'b0;
    wait_done("t4");
    check("t4_naddr", 65'(addr_log.size()), 65'd2);

    // 5: burst ending past the top of the RAM
`ifdef MEMORY_BURST_READER_BOUNDS_CHECK_EN
    addr_log.delete();
    start_burst(8'd255, 3'd1, 8'd1);
    err_cnt = int'(o_error);
    repeat (5) begin
      @(posedge i_clk);
      #1 err_cnt += int'(o_error);
    end
    check("t5_error", 65'(err_cnt), 65'd1);
    check("t5_no_ram", 65'(addr_log.size()), 65'h0);
    check("t5_no_out", 65'(o_valid), 65'h0);
`else
    err_cnt = 0;
    run_burst("t5", 8'd255, 3'd1, 8'd1, 4);
    check("t5_naddr", 65'(addr_log.size()), 65'd2);
    if (addr_log.size() == 2) begin
      check("t5_addr0", 65'(addr_log[0]), 65'd255);
      check("t5_addr1", 65'(addr_log[1]), 65'd0);
    end
    check("t5_error", 65'(o_error), 65'(err_cnt));
`endif

    // 6: reset mid-burst while a word sits in the FIFO
    ready_mode = 2;
    @(posedge i_clk);
    push_expected(8'd0, 3'd0, 8'd8);
    start_burst(8'd0, 3'd0, 8'd8);
    n = 0;
    while (!o_valid && n < 50) begin
      @(posedge i_clk);
      #1 n++;
    end
    check("t6_fill", 65'(o_valid), 65'h1);
    check("t6_busy_pre", 65'(o_busy), 65'h1);
    i_areset_n = 1'b0;
    #1;
    check("t6_valid_rst", 65'(o_valid), 65'h0);
    check("t6_busy_rst", 65'(o_busy), 65'h0);
    sb.delete();
    @(posedge i_clk);
    #2 i_areset_n = 1'b1;
    ready_mode = 0;
    repeat (2) @(posedge i_clk);
    run_burst("t6_after", 8'd1, 3'd0, 8'd1, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
